cp0_exception_ctrl: RTL
=======================

Name: cp0_exception_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller at the M stage of the P8 pipeline. It is the producer side of the fetcher's redirect interface.
- Arbitrates hardware interrupts against synchronous exceptions, including the fetch-side PC exception carried down the pipe. Drives goto_handler (redirect to 0x0000_4180), and holds and returns EPC for ERET.
- Hosts SR/Cause/EPC/PRId for mtc0/mfc0.

Parameters:
PRID, 32'h0000_0008, constant value returned for register 15.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low; sampled low on a clk edge clears state.
pc_m  in  32  PC of the instruction currently in M.
bd_m  in  1  M instruction sits in a branch delay slot.
exc_valid  in  1  M instruction carries a synchronous exception (including fetch-side PC exception).
exc_code  in  5  ExcCode for exc_valid (4 AdEL, 5 AdES, 10 RI, 12 Ov).
hw_int  in  6  hardware interrupt lines, level-sensitive.
cp0_we  in  1  mtc0 in M.
cp0_addr  in  5  CP0 register number for mtc0/mfc0.
cp0_wdata  in  32  mtc0 data.
eret_m  in  1  eret in M.
cp0_rdata  out  32  mfc0 read data, combinational.
goto_handler  out  1  redirect fetch to handler on the next edge.
epc_out  out  32  return address for ERET.
exl  out  1  current SR.EXL.

Behaviour:
- Registers:
  - SR (12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC (14): full 32 bits.
  - PRId (15): PRID.
- Reset (reset low at edge): SR=0, Cause=0, EPC=0. Consequences: goto_handler=0, exl=0, epc_out=0.
  - Reset has priority over every other event in the same cycle.
- Combinational request logic:
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
  - exc_req = exc_valid & ~SR.EXL.
  - goto_handler = int_req | exc_req, asserted in the same cycle as the M-stage condition (zero latency). The fetcher loads 0x4180 on the following edge.
- Priority: interrupt over exception. When int_req, ExcCode is written as 0 and exc_code is ignored.
- On an edge with goto_handler=1:
  - SR.EXL<=1.
  - Cause.BD<=bd_m.
  - Cause.ExcCode<=(int_req ? 0 : exc_code).
  - EPC<=(bd_m ? pc_m-4 : pc_m), 32-bit wrap arithmetic, no alignment forcing.
- Cause.IP<=hw_int on every non-reset edge, independent of masks and EXL.
- mtc0 (cp0_we, no goto_handler on that edge):
  - addr 12 writes SR (writable bits only).
  - addr 14 writes EPC.
  - Writes to 13, 15 and all other addresses are ignored.
- mtc0 coinciding with goto_handler: the write is discarded; the exception update wins.
- eret_m on an edge with goto_handler=0: SR.EXL<=0.
  - eret with EXL already 0 still leaves EXL=0 (no error).
- eret coinciding with goto_handler: eret is ignored, and EXL ends at 1.
- epc_out: EPC register value, with a same-cycle bypass. When cp0_we && cp0_addr==14 && !goto_handler, epc_out=cp0_wdata, so an mtc0-then-eret sequence in adjacent stages resolves correctly.
- cp0_rdata: mux by cp0_addr over 12/13/14/15; any other address reads 0. Reads return the pre-edge register value (no write bypass).
- Masking while EXL=1: no nesting. int_req and exc_req are both 0, and pending hw_int only updates Cause.IP.
- An interrupt unmasked by mtc0 to SR takes effect on the cycle after the write edge.

Test Plan:
- Reset: hold reset=0 for 2 edges with hw_int=6'h3F and cp0_we=1 to addr 12 -> SR=Cause=EPC=0, goto_handler=0, epc_out=0.
- Delay-slot exception: exc_valid=1, exc_code=10, bd_m=1, pc_m=32'h0000_3010, EXL=0 -> goto_handler=1 that cycle; after the edge EPC=32'h0000_300C, Cause=32'h8000_0028, exl=1.
- Interrupt over exception: SR=32'h0000_0401, hw_int=6'h01, exc_valid=1 (code 12), pc_m=32'h3020 -> ExcCode=0, EPC=32'h3020. A second exc_valid next cycle -> goto_handler=0 (EXL masks it).
- mtc0+eret bypass: EXL=1, cp0_we=1 to addr 14 with data 32'h0000_3400, eret_m=1 same cycle -> epc_out=32'h0000_3400 combinationally; after the edge EPC=32'h3400, exl=0.
- Collision: mtc0 addr 12 data 0 alongside exc_valid (code 4), pc_m=32'h0000_3002 -> SR.EXL=1 (write dropped), EPC=32'h0000_3002, ExcCode=4.
- mfc0 map: read addrs 15, 13, 7 -> PRID, Cause with IP mirroring hw_int from the prior edge, and 0 respectively.

Source files
------------

// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: M-stage CP0 exception/interrupt arbiter with SR/Cause/EPC/PRId.
// Raises goto_handler in the same cycle as the request and records EPC/Cause on that edge.
module cp0_exception_ctrl #(
    parameter logic [31:0] PRID = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret_m,
    output logic [31:0] cp0_rdata,
    output logic        goto_handler,
    output logic [31:0] epc_out,
    output logic        exl
);
    logic [5:0]  im_q, im_d, ip_q, ip_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d, sr, cause;
    logic        int_req, exc_req, wr_sr, wr_epc;

    assign int_req      = |(hw_int & im_q) & ie_q & ~exl_q;
    assign exc_req      = exc_valid & ~exl_q;
    assign goto_handler = int_req | exc_req;
    assign wr_sr        = cp0_we && cp0_addr == 5'd12 && !goto_handler;
    assign wr_epc       = cp0_we && cp0_addr == 5'd14 && !goto_handler;
    assign sr           = {16'h0, im_q, 8'h0, exl_q, ie_q};
    assign cause        = {bd_q, 15'h0, ip_q, 3'h0, code_q, 2'h0};
    assign exl          = exl_q;
    // Bypass lets an mtc0 EPC immediately followed by eret return the new address.
    assign epc_out      = wr_epc ? cp0_wdata : epc_q;
    assign cp0_rdata    = cp0_addr == 5'd12 ? sr :
                          cp0_addr == 5'd13 ? cause :
                          cp0_addr == 5'd14 ? epc_q :
                          cp0_addr == 5'd15 ? PRID : 32'h0;

    always_comb begin
        im_d   = wr_sr ? cp0_wdata[15:10] : im_q;
        ie_d   = wr_sr ? cp0_wdata[0] : ie_q;
        exl_d  = goto_handler ? 1'b1 : eret_m ? 1'b0 : wr_sr ? cp0_wdata[1] : exl_q;
        ip_d   = hw_int;
        bd_d   = goto_handler ? bd_m : bd_q;
        code_d = goto_handler ? (int_req ? 5'd0 : exc_code) : code_q;
        epc_d  = goto_handler ? (bd_m ? pc_m - 32'd4 : pc_m) : wr_epc ? cp0_wdata : epc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q   <= '0;
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            ip_q   <= '0;
            bd_q   <= 1'b0;
            code_q <= '0;
            epc_q  <= '0;
        end else begin
            im_q   <= im_d;
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            ip_q   <= ip_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end
endmodule
